hdmi_frame_capture_pack: RTL and testbench
==========================================

Name: hdmi_frame_capture_pack

Overview:
- Write-side front end of the HDMI capture path, in the hdmi_in_clk domain.
- Measures incoming timing and qualifies frame stability, then crops a window, decimates in X/Y and packs pixels as RGB888 (1 pixel/word) or RGB565 (2 pixels/word).
- Emits a valid/ready 32-bit word stream with frame/line markers into the downstream async FIFO.
- On backpressure it drops the remainder of the frame and resumes cleanly at the next frame; it never resumes mid-frame.

Parameters:
- CNT_W, 12, width of pixel/line counters and window fields
- STABLE_FRAMES, 2, consecutive identical frame measurements required before frame_ready
- VS_ACTIVE_HIGH, 1, vsync polarity (1: active-high pulse; 0: active-low)
- DROP_CNT_W, 8, width of saturating dropped-frame counter

Ports:
- hdmi_in_clk  in  1  pixel clock
- hdmi_in_rstn  in  1  async active-low reset
- hdmi_in_vsync  in  1  vertical sync
- hdmi_in_de  in  1  data enable
- hdmi_in_rgb  in  24  {R,G,B} pixel
- capture_on  in  1  enable capture
- fmt_565  in  1  0: RGB888 {8'hFF,RGB}; 1: RGB565 packed
- dec_x_log2  in  2  X decimation 1/2/4 (value 3 treated as 2)
- dec_y_log2  in  2  Y decimation 1/2/4 (value 3 treated as 2)
- win_x, win_y  in  CNT_W each  crop origin
- win_w, win_h  in  CNT_W each  crop size; 0 = to end of line/frame
- out_valid  out  1  word valid
- out_ready  in  1  downstream accept
- out_data  out  32  packed pixels
- out_sof  out  1  first word of frame
- out_eol  out  1  last word of line
- frame_ready  out  1  timing stable
- frame_height_width  out  32  {4'b0,height,4'b0,width}, zero-extended to 12 bits
- frames_done  out  16  completed frames, wrapping
- drop_cnt  out  DROP_CNT_W  dropped frames, saturating
- overflow  out  1  sticky; cleared on capture_on rising edge

Behaviour:
- Reset: all outputs 0, FSM IDLE.
- Input stage: vsync/de/rgb registered once (d1) plus a vsync d2 for edge detection.
- SOF = vsync deasserting edge (polarity per VS_ACTIVE_HIGH); EOF = vsync asserting edge.
- Measurement:
  - width = DE-high count per line (de falling edge).
  - height = line count between EOFs.
  - Latched at EOF only if nonzero.
  - stable_cnt increments (saturating) when the new w/h equal the previous, else clears to 0.
  - frame_ready = stable_cnt >= STABLE_FRAMES-1 and both nonzero.
- FSM IDLE/WAIT_SOF/ACTIVE/DROP:
  - capture_on=0 forces IDLE from any state and clears out_valid next cycle; downstream FIFO is reset by the same condition.
  - IDLE->WAIT_SOF when capture_on=1.
  - WAIT_SOF->ACTIVE on SOF with frame_ready=1. fmt/dec/win inputs are latched at this transition and are stable for the whole frame; changes mid-frame apply next frame.
  - ACTIVE->WAIT_SOF on EOF; frames_done+1 if no drop occurred.
  - ACTIVE->DROP when a word must be produced while out_valid=1 and out_ready=0. In that case: overflow<=1, drop_cnt+1 (saturating), the in-flight word is not corrupted.
  - DROP->WAIT_SOF on EOF.
  - frame_ready falling while ACTIVE -> DROP.
- Pixel keep rule: x in [win_x, win_x+win_w) and y in [win_y, win_y+win_h) (0 size = unbounded), AND low dec_x_log2 bits of (x-win_x) zero, AND low dec_y_log2 bits of (y-win_y) zero. x/y count active pixels/lines from 0.
- Packing:
  - 888: one word per kept pixel.
  - 565: first kept pixel -> [15:0], second -> [31:16], word emitted on second. An odd trailing pixel at line end is emitted with [31:16]=16'h0000.
  - 565 conversion {R[7:3],G[7:2],B[7:3]}.
- out_eol on the last word of each kept line; out_sof on the first word of the frame.
- Output register: loads when !out_valid || out_ready. Payload stable while out_valid && !out_ready.
- Latency: pixel on inputs at cycle t -> out_valid at t+2 (888), or t+2 after the second pixel (565).
- Simultaneous EOF and last-pixel word: the word is emitted, then EOF is processed.
- Reset mid-frame: immediate IDLE; output cleared.

Decomposition:
- Package hdmi_cap_pkg: FSM state encoding, fmt codes, 565 conversion function, alpha constant 8'hFF.
- Sub-module hdmi_timing_measure: edge detect, w/h measurement, stability counter, frame_ready.

Test Plan:
- 64x8 frames, capture_on=1, 888, no crop/dec, out_ready=1 -> frame_ready after frame 2. Third frame: 512 words, first {8'hFF,rgb0} with sof, eol every 64th word, frames_done=1.
- 565, win_x=1 win_w=5 on 64x8 -> 3 words/line; word3 [31:16]=0 with eol. Pixel 0xF8FC F8 -> 16'hFFFF.
- dec_x_log2=1, dec_y_log2=2, 64x8 -> 32 words/line on lines 0 and 4 only, 64 words total.
- out_ready held 0 mid-frame -> one word held stable. overflow=1, drop_cnt=1, no further words until next SOF. Next frame complete with sof.
- Width changes 64->60 -> frame_ready drops, ACTIVE->DROP. Re-qualifies after 2 frames at 60.
- capture_on deasserted mid-line -> out_valid 0 next cycle, IDLE. Re-enable -> overflow cleared, capture starts at next qualified SOF.

Source files
------------

// File: rtl/hdmi_cap_pkg.sv
// Shared types for the HDMI capture write path: FSM states, pixel format codes,
// the fixed alpha byte used in RGB888 words and the RGB565 conversion.
package hdmi_cap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_DROP     = 2'd3
    } cap_state_e;

    typedef enum logic {
        FMT_888 = 1'b0,
        FMT_565 = 1'b1
    } pix_fmt_e;

    localparam logic [7:0] ALPHA = 8'hFF;

    function automatic logic [15:0] rgb_to_565(input logic [23:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

endpackage

// File: rtl/hdmi_timing_measure.sv
// Registers sync/DE, finds SOF/EOF edges, measures w/h per frame and qualifies stability.
// Edges are one cycle behind the pins; no backpressure, the video timing is free-running.
module hdmi_timing_measure #(
    parameter int CNT_W          = 12,
    parameter int STABLE_FRAMES  = 2,
    parameter int VS_ACTIVE_HIGH = 1
) (
    input  logic             hdmi_in_clk,
    input  logic             hdmi_in_rstn,
    input  logic             vsync_i,
    input  logic             de_i,
    output logic             de_d1_o,
    output logic             de_fall_o,
    output logic             sof_o,
    output logic             eof_o,
    output logic             frame_ready_o,
    output logic [CNT_W-1:0] width_o,
    output logic [CNT_W-1:0] height_o
);

    localparam logic [7:0] STABLE_THR = 8'(STABLE_FRAMES - 1);

    logic             vs_d1_q, vs_d2_q, de_d1_q, de_d2_q;
    logic             vs_act1, vs_act2;
    logic [CNT_W-1:0] pix_cnt_q, line_w_q, line_cnt_q, width_q, height_q;
    logic [7:0]       stable_q;

    assign vs_act1   = (VS_ACTIVE_HIGH != 0) ? vs_d1_q : ~vs_d1_q;
    assign vs_act2   = (VS_ACTIVE_HIGH != 0) ? vs_d2_q : ~vs_d2_q;
    assign sof_o     = vs_act2 & ~vs_act1;
    assign eof_o     = ~vs_act2 & vs_act1;
    assign de_fall_o = de_d2_q & ~de_d1_q;
    assign de_d1_o   = de_d1_q;

    always_ff @(posedge hdmi_in_clk or negedge hdmi_in_rstn) begin
        if (!hdmi_in_rstn) begin
            vs_d1_q    <= 1'b0;
            vs_d2_q    <= 1'b0;
            de_d1_q    <= 1'b0;
            de_d2_q    <= 1'b0;
            pix_cnt_q  <= '0;
            line_w_q   <= '0;
            line_cnt_q <= '0;
            width_q    <= '0;
            height_q   <= '0;
            stable_q   <= '0;
        end else begin
            vs_d1_q <= vsync_i;
            vs_d2_q <= vs_d1_q;
            de_d1_q <= de_i;
            de_d2_q <= de_d1_q;
            if (de_d1_q) begin
                pix_cnt_q <= pix_cnt_q + 1'b1;
            end else if (de_fall_o) begin
                pix_cnt_q <= '0;
                line_w_q  <= pix_cnt_q;
            end
            if (eof_o) begin
                line_cnt_q <= '0;
                // An empty measurement (no lines seen) keeps the last good timing.
                if (line_w_q != '0 && line_cnt_q != '0) begin
                    width_q  <= line_w_q;
                    height_q <= line_cnt_q;
                    if (line_w_q == width_q && line_cnt_q == height_q) begin
                        if (stable_q != 8'hFF) stable_q <= stable_q + 8'd1;
                    end else begin
                        stable_q <= '0;
                    end
                end
            end else if (de_fall_o) begin
                line_cnt_q <= line_cnt_q + 1'b1;
            end
        end
    end

    assign frame_ready_o = (stable_q >= STABLE_THR) && (width_q != '0) && (height_q != '0);
    assign width_o       = width_q;
    assign height_o      = height_q;

endmodule

// File: rtl/hdmi_frame_capture_pack.sv
// Crop/decimate/pack HDMI pixels into a 32-bit valid/ready word stream; pixel to word in 2 cycles.
// A word that cannot be loaded under backpressure abandons the rest of the frame until the next SOF.
module hdmi_frame_capture_pack
    import hdmi_cap_pkg::*;
#(
    parameter int CNT_W          = 12,
    parameter int STABLE_FRAMES  = 2,
    parameter int VS_ACTIVE_HIGH = 1,
    parameter int DROP_CNT_W     = 8
) (
    input  logic                  hdmi_in_clk,
    input  logic                  hdmi_in_rstn,
    input  logic                  hdmi_in_vsync,
    input  logic                  hdmi_in_de,
    input  logic [23:0]           hdmi_in_rgb,
    input  logic                  capture_on,
    input  logic                  fmt_565,
    input  logic [1:0]            dec_x_log2,
    input  logic [1:0]            dec_y_log2,
    input  logic [CNT_W-1:0]      win_x,
    input  logic [CNT_W-1:0]      win_y,
    input  logic [CNT_W-1:0]      win_w,
    input  logic [CNT_W-1:0]      win_h,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  frame_ready,
    output logic [31:0]           frame_height_width,
    output logic [15:0]           frames_done,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  overflow
);

    cap_state_e state_q, state_d;
    pix_fmt_e   fmt_q;

    logic                  de_d1, de_fall, sof, eof, frame_ready_w;
    logic [CNT_W-1:0]      meas_w, meas_h;
    logic [23:0]           rgb_d1_q;
    logic [CNT_W-1:0]      x_q, y_q, winx_q, winy_q, winw_q, winh_q;
    logic [1:0]            decx_q, decy_q;
    logic                  half_q, first_q, cap_prev_q;
    logic [15:0]           lo_q, c565;
    logic                  out_valid_q, out_sof_q, out_eol_q, overflow_q;
    logic [31:0]           out_data_q, word;
    logic [15:0]           frames_q;
    logic [DROP_CNT_W-1:0] drop_q;

    logic [CNT_W-1:0] dx, dy;
    logic [CNT_W:0]   step, win_end, x_end;
    logic             x_in, y_in, x_dec_ok, y_dec_ok, keep, last, is565;
    logic             produce, load_ok, drop_evt, done_evt, start;

    hdmi_timing_measure #(
        .CNT_W          (CNT_W),
        .STABLE_FRAMES  (STABLE_FRAMES),
        .VS_ACTIVE_HIGH (VS_ACTIVE_HIGH)
    ) u_meas (
        .hdmi_in_clk   (hdmi_in_clk),
        .hdmi_in_rstn  (hdmi_in_rstn),
        .vsync_i       (hdmi_in_vsync),
        .de_i          (hdmi_in_de),
        .de_d1_o       (de_d1),
        .de_fall_o     (de_fall),
        .sof_o         (sof),
        .eof_o         (eof),
        .frame_ready_o (frame_ready_w),
        .width_o       (meas_w),
        .height_o      (meas_h)
    );

    assign dx       = x_q - winx_q;
    assign dy       = y_q - winy_q;
    assign x_in     = (x_q >= winx_q) && (winw_q == '0 || dx < winw_q);
    assign y_in     = (y_q >= winy_q) && (winh_q == '0 || dy < winh_q);
    assign x_dec_ok = (decx_q == 2'd0) ? 1'b1 : (decx_q == 2'd1) ? ~dx[0] : (dx[1:0] == 2'b00);
    assign y_dec_ok = (decy_q == 2'd0) ? 1'b1 : (decy_q == 2'd1) ? ~dy[0] : (dy[1:0] == 2'b00);
    assign keep     = de_d1 && x_in && y_in && x_dec_ok && y_dec_ok;
    assign is565    = (fmt_q == FMT_565);

    // Last kept pixel of a line: the next decimation step falls past the window or the
    // measured line end, or DE is already dropping on the pins.
    assign step    = (CNT_W+1)'(1) << decx_q;
    assign win_end = {1'b0, winx_q} + {1'b0, winw_q};
    assign x_end   = (winw_q == '0 || win_end > {1'b0, meas_w}) ? {1'b0, meas_w} : win_end;
    assign last    = ~hdmi_in_de | (({1'b0, x_q} + step) >= x_end);

    assign c565    = rgb_to_565(rgb_d1_q);
    assign word    = !is565 ? {ALPHA, rgb_d1_q} : (half_q ? {c565, lo_q} : {16'h0000, c565});
    assign produce = (state_q == ST_ACTIVE) && keep && (!is565 || half_q || last);
    assign load_ok = !out_valid_q || out_ready;
    assign start   = (state_q == ST_WAIT_SOF) && (state_d == ST_ACTIVE);

    always_comb begin
        state_d  = state_q;
        drop_evt = 1'b0;
        done_evt = 1'b0;
        case (state_q)
            ST_IDLE:     if (capture_on) state_d = ST_WAIT_SOF;
            ST_WAIT_SOF: if (sof && frame_ready_w) state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (produce && !load_ok) begin
                    drop_evt = 1'b1;
                    state_d  = eof ? ST_WAIT_SOF : ST_DROP;
                end else if (eof) begin
                    done_evt = 1'b1;
                    state_d  = ST_WAIT_SOF;
                end else if (!frame_ready_w) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP:     if (eof) state_d = ST_WAIT_SOF;
            default:     state_d = ST_IDLE;
        endcase
        if (!capture_on) begin
            state_d  = ST_IDLE;
            drop_evt = 1'b0;
            done_evt = 1'b0;
        end
    end

    always_ff @(posedge hdmi_in_clk or negedge hdmi_in_rstn) begin
        if (!hdmi_in_rstn) begin
            state_q     <= ST_IDLE;
            fmt_q       <= FMT_888;
            rgb_d1_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            winx_q      <= '0;
            winy_q      <= '0;
            winw_q      <= '0;
            winh_q      <= '0;
            decx_q      <= '0;
            decy_q      <= '0;
            half_q      <= 1'b0;
            first_q     <= 1'b0;
            lo_q        <= '0;
            cap_prev_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            overflow_q  <= 1'b0;
            frames_q    <= '0;
            drop_q      <= '0;
        end else begin
            state_q    <= state_d;
            rgb_d1_q   <= hdmi_in_rgb;
            cap_prev_q <= capture_on;
            x_q        <= de_d1 ? x_q + 1'b1 : '0;
            if (sof)          y_q <= '0;
            else if (de_fall) y_q <= y_q + 1'b1;

            if (start) begin
                fmt_q   <= fmt_565 ? FMT_565 : FMT_888;
                decx_q  <= (dec_x_log2 == 2'd3) ? 2'd2 : dec_x_log2;
                decy_q  <= (dec_y_log2 == 2'd3) ? 2'd2 : dec_y_log2;
                winx_q  <= win_x;
                winy_q  <= win_y;
                winw_q  <= win_w;
                winh_q  <= win_h;
                first_q <= 1'b1;
                half_q  <= 1'b0;
            end else if (!de_d1 || produce) begin
                half_q <= 1'b0;
            end else if (state_q == ST_ACTIVE && keep && is565) begin
                half_q <= 1'b1;
                lo_q   <= c565;
            end

            if (!capture_on) begin
                out_valid_q <= 1'b0;
            end else if (produce && load_ok) begin
                out_valid_q <= 1'b1;
                out_data_q  <= word;
                out_sof_q   <= first_q;
                out_eol_q   <= last;
                first_q     <= 1'b0;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (done_evt) frames_q <= frames_q + 16'd1;
            if (drop_evt && drop_q != '1) drop_q <= drop_q + 1'b1;
            if (capture_on && !cap_prev_q) overflow_q <= 1'b0;
            else if (drop_evt)             overflow_q <= 1'b1;
        end
    end

    assign out_valid          = out_valid_q;
    assign out_data           = out_data_q;
    assign out_sof            = out_sof_q;
    assign out_eol            = out_eol_q;
    assign frame_ready        = frame_ready_w;
    assign frame_height_width = {4'b0, 12'(meas_h), 4'b0, 12'(meas_w)};
    assign frames_done        = frames_q;
    assign drop_cnt           = drop_q;
    assign overflow           = overflow_q;

endmodule

// File: tb/tb_hdmi_frame_capture_pack.sv
// Frame-level bench: expected words are queued as each frame starts and compared as the
// DUT hands them off; frame counters, readiness and sticky status are checked between frames.
module tb_hdmi_frame_capture_pack;

    logic        clk = 1'b0;
    logic        rstn;
    logic        vsync, de, capture_on, fmt_565, out_ready;
    logic [23:0] rgb;
    logic [1:0]  dec_x_log2, dec_y_log2;
    logic [11:0] win_x, win_y, win_w, win_h;
    logic        out_valid, out_sof, out_eol, frame_ready, overflow;
    logic [31:0] out_data, frame_height_width;
    logic [15:0] frames_done;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int n_acc    = 0;
    int fcnt     = 0;
    int c_fmt, c_dx, c_dy, c_wx, c_wy, c_ww, c_wh;

    logic [33:0] sb[$];

    always #5 clk = ~clk;

    hdmi_frame_capture_pack dut (
        .hdmi_in_clk        (clk),
        .hdmi_in_rstn       (rstn),
        .hdmi_in_vsync      (vsync),
        .hdmi_in_de         (de),
        .hdmi_in_rgb        (rgb),
        .capture_on         (capture_on),
        .fmt_565            (fmt_565),
        .dec_x_log2         (dec_x_log2),
        .dec_y_log2         (dec_y_log2),
        .win_x              (win_x),
        .win_y              (win_y),
        .win_w              (win_w),
        .win_h              (win_h),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_sof            (out_sof),
        .out_eol            (out_eol),
        .frame_ready        (frame_ready),
        .frame_height_width (frame_height_width),
        .frames_done        (frames_done),
        .drop_cnt           (drop_cnt),
        .overflow           (overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int x, input int y, input int f);
        if (x == 1 && y == 0) return 24'hF8FCF8;
        return {8'(x * 3 + f), 8'(y * 17 + x), 8'(f * 29 + (x ^ y))};
    endfunction

    function automatic logic [15:0] to565(input logic [23:0] p);
        return {p[23:19], p[15:10], p[7:3]};
    endfunction

    function automatic bit kept(input int p, input int org, input int sz, input int dec);
        int d;
        d = (dec == 3) ? 2 : dec;
        if (p < org) return 1'b0;
        if (sz != 0 && p >= org + sz) return 1'b0;
        return ((p - org) % (1 << d)) == 0;
    endfunction

    task automatic set_cfg(input int f, input int dx, input int dy, input int wx,
                           input int wy, input int ww, input int wh);
        c_fmt = f; c_dx = dx; c_dy = dy; c_wx = wx; c_wy = wy; c_ww = ww; c_wh = wh;
        fmt_565    = 1'(f);
        dec_x_log2 = 2'(dx);
        dec_y_log2 = 2'(dy);
        win_x      = 12'(wx);
        win_y      = 12'(wy);
        win_w      = 12'(ww);
        win_h      = 12'(wh);
    endtask

    task automatic push_frame(input int w, input int h);
        bit first = 1'b1;
        for (int y = 0; y < h; y++) begin
            int kx[$];
            int n;
            if (!kept(y, c_wy, c_wh, c_dy)) continue;
            for (int x = 0; x < w; x++)
                if (kept(x, c_wx, c_ww, c_dx)) kx.push_back(x);
            n = kx.size();
            if (c_fmt == 0) begin
                for (int i = 0; i < n; i++) begin
                    sb.push_back({first, (i == n - 1), 8'hFF, pix(kx[i], y, fcnt)});
                    first = 1'b0;
                end
            end else begin
                for (int i = 0; i < n; i += 2) begin
                    logic [15:0] hi;
                    hi = (i + 1 < n) ? to565(pix(kx[i+1], y, fcnt)) : 16'h0000;
                    sb.push_back({first, (i + 2 >= n), hi, to565(pix(kx[i], y, fcnt))});
                    first = 1'b0;
                end
            end
        end
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1 vsync = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int w, input int h, input bit cap, input int kill_y,
                             output bit fr_sof, output int fd_sof);
        vs_pulse();
        fr_sof = frame_ready;
        fd_sof = int'(frames_done);
        fcnt++;
        if (cap) push_frame(w, h);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                de  = 1'b1;
                rgb = pix(x, y, fcnt);
                if (y == kill_y && x == 20) capture_on = 1'b0;
                @(posedge clk);
                #1;
                if (y == kill_y && x == 20) check("kill_valid", out_valid, 0);
            end
            de = 1'b0;
            repeat (8) @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            n_acc++;
            if (sb.size() == 0) check("sb_nonempty", sb.size(), 1);
            else                check("word", {out_sof, out_eol, out_data}, sb.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          fr;
        int          fd, base, rel;
        logic [31:0] held;

        rstn = 1'b0; vsync = 1'b0; de = 1'b0; rgb = '0;
        capture_on = 1'b0; out_ready = 1'b1;
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sof_eol", {out_sof, out_eol}, 0);
        check("rst_ready", frame_ready, 0);
        check("rst_hw", frame_height_width, 0);
        check("rst_done", frames_done, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_ovf", overflow, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1 capture_on = 1'b1;

        // Qualification: two measured frames before the first capture.
        run_frame(64, 8, 0, -1, fr, fd);  check("f1_ready", fr, 0);
        run_frame(64, 8, 0, -1, fr, fd);  check("f2_ready", fr, 0);
        base = n_acc;
        run_frame(64, 8, 1, -1, fr, fd);
        check("f3_ready", fr, 1);
        check("f3_done", fd, 0);
        check("f3_hw", frame_height_width, 32'h0008_0040);
        check("f3_words", n_acc - base, 512);
        check("f3_sb_empty", sb.size(), 0);

        set_cfg(1, 0, 0, 1, 0, 5, 0);
        base = n_acc;
        run_frame(64, 8, 1, -1, fr, fd);
        check("f4_done", fd, 1);
        check("f4_words", n_acc - base, 24);

        set_cfg(0, 1, 2, 0, 0, 0, 0);
        base = n_acc;
        run_frame(64, 8, 1, -1, fr, fd);
        check("f5_done", fd, 2);
        check("f5_words", n_acc - base, 64);

        // Backpressure mid-frame: the held word survives, the rest of the frame is dropped.
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        base = n_acc;
        rel  = 0;
        fork
            run_frame(64, 8, 1, -1, fr, fd);
            begin
                int t = 0;
                while (n_acc < base + 100 && t < 5000) begin
                    @(posedge clk);
                    t++;
                end
                if (t >= 5000) check("stall_wait", n_acc - base, 100);
                #1 out_ready = 1'b0;
                @(negedge clk);
                held = out_data;
                repeat (20) @(negedge clk);
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held);
                @(posedge clk);
                #1 out_ready = 1'b1;
                rel = n_acc;
            end
        join
        check("f6_done", fd, 3);
        check("f6_tail_words", n_acc - rel, 1);
        check("f6_ovf", overflow, 1);
        check("f6_drop", drop_cnt, 1);
        sb.delete();

        base = n_acc;
        run_frame(64, 8, 1, -1, fr, fd);
        check("f7_done", fd, 3);
        check("f7_words", n_acc - base, 512);

        // Width change: the 60-wide frame starts while still qualified, then readiness drops.
        base = n_acc;
        run_frame(60, 8, 1, -1, fr, fd);
        check("f8_ready", fr, 1);
        check("f8_done", fd, 4);
        check("f8_words", n_acc - base, 480);
        base = n_acc;
        run_frame(60, 8, 0, -1, fr, fd);
        check("f9_ready", fr, 0);
        check("f9_done", fd, 5);
        check("f9_hw", frame_height_width, 32'h0008_003C);
        check("f9_words", n_acc - base, 0);
        base = n_acc;
        run_frame(60, 8, 1, -1, fr, fd);
        check("f10_ready", fr, 1);
        check("f10_words", n_acc - base, 480);

        // Capture disabled mid-line, then re-enabled before the next frame.
        base = n_acc;
        run_frame(60, 8, 1, 2, fr, fd);
        check("f11_done", fd, 6);
        check("f11_cut", (n_acc - base) < 480, 1);
        sb.delete();
        capture_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("reen_ovf", overflow, 0);

        base = n_acc;
        run_frame(60, 8, 1, -1, fr, fd);
        check("f12_done", fd, 6);
        check("f12_words", n_acc - base, 480);
        vs_pulse();
        repeat (5) @(posedge clk);
        #1;
        check("end_done", frames_done, 7);
        check("end_drop", drop_cnt, 1);
        check("end_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
